// File: rtl/adda_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adda_pkg
//  Description : Shared types and helpers for the AD/DA serial frame
//                controller: frame state encoding, parameter legality check
//                and DAC word assembly.
//  Revision    : 1.0 - initial release
// ============================================================================
package adda_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4,
    ST_GAP   = 3'd5
  } adda_state_e;

  // Widest frame the word assembly helper can produce.
  localparam int c_max_word_w = 64;

  // True when the parameter set describes a buildable frame controller.
  function automatic bit adda_params_ok(input int width, input int data_w,
                                        input int ch_w, input int div);
    return (data_w >= 1) && (data_w <= 32) &&
           (ch_w >= 1) && (ch_w <= 32) &&
           (width >= ch_w + data_w) && (width <= c_max_word_w) &&
           (div >= 1);
  endfunction

  // Channel in the top ch_w bits, data in the low data_w bits, zeros between.
  function automatic logic [c_max_word_w-1:0] adda_dac_word(
      input int width, input int data_w, input int ch_w,
      input logic [31:0] ch, input logic [31:0] data);
    logic [c_max_word_w-1:0] w;
    w = '0;
    for (int i = 0; i < data_w; i++) w[i] = data[i];
    for (int i = 0; i < ch_w; i++) w[width-ch_w+i] = ch[i];
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adda_sck_div.sv
`default_nettype none
// ============================================================================
//  Module      : adda_sck_div
//  Description : SCK half-period divider. Counts DIV enabled cycles and
//                strobes o_tick on the last cycle of each half period.
//  Ports       : clk, rst_n (async, active low), i_clr (restart count),
//                i_en (count enable), o_tick (half-period end strobe)
//  Revision    : 1.0 - initial release
// ============================================================================
module adda_sck_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int c_cnt_w = $clog2(DIV) + 1;

  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  assign o_tick = i_en && (cnt_q == c_cnt_w'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)       cnt_d = '0;
    else if (o_tick) cnt_d = '0;
    else if (i_en)   cnt_d = cnt_q + c_cnt_w'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/adda_serial_frame.sv
`default_nettype none
// ============================================================================
//  Module      : adda_serial_frame
//  Description : Full-duplex serial frame controller for the AD/DA board.
//                One request shifts a channel-addressed word to the DAC
//                (MSB first) while capturing one sample from the ADC.
//  Ports       : CLK, RST_N (async, active low); START/BUSY/DONE handshake;
//                LOOPBACK selects ADC_DATA as the DAC sample source;
//                DAC_DATA/DAC_CH sample and channel; ADC_DATA last sample;
//                SCK, SDOUT, SDIN, CS_ADC, LD_DAC converter pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module adda_serial_frame
  import adda_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DATA_W = 12,
  parameter int CH_W   = 2,
  parameter int DIV    = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              LOOPBACK,
  input  logic [DATA_W-1:0] DAC_DATA,
  input  logic [CH_W-1:0]   DAC_CH,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] ADC_DATA,
  output logic              SCK,
  input  logic              SDOUT,
  output logic              SDIN,
  output logic              CS_ADC,
  output logic              LD_DAC
);

  if (!adda_params_ok(WIDTH, DATA_W, CH_W, DIV)) begin : g_bad_params
    $error("adda_serial_frame: illegal WIDTH/DATA_W/CH_W/DIV combination");
  end

  localparam int c_bit_w = $clog2(WIDTH) + 1;

  adda_state_e         state_q, state_d;
  logic                sck_q, sck_d;
  logic                cs_n_q, cs_n_d;
  logic                sdin_q, sdin_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [WIDTH-1:0]    dac_sr_q, dac_sr_d;
  logic [DATA_W-1:0]   adc_sr_q, adc_sr_d;
  logic [DATA_W-1:0]   adc_data_q, adc_data_d;
  logic [c_bit_w-1:0]  bit_cnt_q, bit_cnt_d;

  logic [WIDTH-1:0]    w_word;
  logic                w_tick;
  logic                w_div_clr;
  logic                w_div_en;

  // Word source is sampled only at accept, so later LOOPBACK changes are inert.
  assign w_word = WIDTH'(adda_dac_word(WIDTH, DATA_W, CH_W, 32'(DAC_CH),
                         32'(LOOPBACK ? adc_data_q : DAC_DATA)));

  // The divider is frozen during the single DONE cycle so GAP gets a full DIV.
  assign w_div_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                    (state_q == ST_HOLD)  || (state_q == ST_GAP);

  adda_sck_div #(.DIV(DIV)) u_sck_div (
    .clk    (CLK),
    .rst_n  (RST_N),
    .i_clr  (w_div_clr),
    .i_en   (w_div_en),
    .o_tick (w_tick)
  );

  always_comb begin
    state_d    = state_q;
    sck_d      = sck_q;
    cs_n_d     = cs_n_q;
    sdin_d     = sdin_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dac_sr_d   = dac_sr_q;
    adc_sr_d   = adc_sr_q;
    adc_data_d = adc_data_q;
    bit_cnt_d  = bit_cnt_q;
    w_div_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d   = ST_SETUP;
          busy_d    = 1'b1;
          cs_n_d    = 1'b0;
          sck_d     = 1'b1;
          dac_sr_d  = w_word;
          sdin_d    = w_word[WIDTH-1];
          bit_cnt_d = '0;
          w_div_clr = 1'b1;
        end
      end
      ST_SETUP: begin
        if (w_tick) begin
          state_d = ST_SHIFT;
          sck_d   = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (w_tick) begin
          if (!sck_q) begin
            // Rising SCK: capture the ADC bit presented on the last fall.
            sck_d     = 1'b1;
            adc_sr_d  = (adc_sr_q << 1) | DATA_W'(SDOUT);
            bit_cnt_d = bit_cnt_q + c_bit_w'(1);
          end else if (bit_cnt_q == c_bit_w'(WIDTH)) begin
            state_d = ST_HOLD;
          end else begin
            // Falling SCK after the first: advance to the next DAC bit.
            sck_d    = 1'b0;
            sdin_d   = dac_sr_q[WIDTH-2];
            dac_sr_d = dac_sr_q << 1;
          end
        end
      end
      ST_HOLD: begin
        if (w_tick) begin
          state_d    = ST_DONE;
          cs_n_d     = 1'b1;
          sdin_d     = 1'b0;
          done_d     = 1'b1;
          adc_data_d = adc_sr_q;
        end
      end
      ST_DONE: begin
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (w_tick) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      sck_q      <= 1'b1;
      cs_n_q     <= 1'b1;
      sdin_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dac_sr_q   <= '0;
      adc_sr_q   <= '0;
      adc_data_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sck_q      <= sck_d;
      cs_n_q     <= cs_n_d;
      sdin_q     <= sdin_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dac_sr_q   <= dac_sr_d;
      adc_sr_q   <= adc_sr_d;
      adc_data_q <= adc_data_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign SCK      = sck_q;
  assign SDIN     = sdin_q;
  assign CS_ADC   = cs_n_q;
  assign LD_DAC   = cs_n_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ADC_DATA = adc_data_q;

endmodule
`default_nettype wire

// File: tb/tb_adda_serial_frame.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adda_serial_frame
//  Description : Self-checking bench for adda_serial_frame. Instance A uses
//                the default parameters, instance B uses WIDTH=24, DATA_W=16,
//                CH_W=4, DIV=1. A timing model derived from the frame rules
//                is compared against both instances every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adda_serial_frame;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  start_v = '0;
  logic [1:0]  loop_v  = '0;
  logic        sdout_a = 1'b0;
  logic        sdout_b = 1'b0;
  logic [11:0] data_a  = '0;
  logic [1:0]  ch_a    = '0;
  logic [15:0] data_b  = '0;
  logic [3:0]  ch_b    = '0;
  logic [31:0] pat_v [2];

  wire [1:0]  busy_w, done_w, sck_w, sdin_w, cs_w, ld_w;
  wire [11:0] adc_a;
  wire [15:0] adc_b;

  adda_serial_frame u_dut_a (
    .CLK(clk), .RST_N(rst_n), .START(start_v[0]), .LOOPBACK(loop_v[0]),
    .DAC_DATA(data_a), .DAC_CH(ch_a), .BUSY(busy_w[0]), .DONE(done_w[0]),
    .ADC_DATA(adc_a), .SCK(sck_w[0]), .SDOUT(sdout_a), .SDIN(sdin_w[0]),
    .CS_ADC(cs_w[0]), .LD_DAC(ld_w[0])
  );

  adda_serial_frame #(.WIDTH(24), .DATA_W(16), .CH_W(4), .DIV(1)) u_dut_b (
    .CLK(clk), .RST_N(rst_n), .START(start_v[1]), .LOOPBACK(loop_v[1]),
    .DAC_DATA(data_b), .DAC_CH(ch_b), .BUSY(busy_w[1]), .DONE(done_w[1]),
    .ADC_DATA(adc_b), .SCK(sck_w[1]), .SDOUT(sdout_b), .SDIN(sdin_w[1]),
    .CS_ADC(cs_w[1]), .LD_DAC(ld_w[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-instance parameters.
  function automatic int pw(input int i);  return (i == 0) ? 16 : 24; endfunction
  function automatic int pd(input int i);  return (i == 0) ? 4 : 1;   endfunction
  function automatic int pcw(input int i); return (i == 0) ? 2 : 4;   endfunction
  function automatic int pdw(input int i); return (i == 0) ? 12 : 16; endfunction
  // Offset of the DONE cycle from the accept cycle.
  function automatic int fend(input int i);
    return 1 + (2 + 2 * pw(i)) * pd(i);
  endfunction

  // ---------------- ADC source models: next bit on each SCK fall ----------
  int idx_a = 0;
  int idx_b = 0;
  always @(negedge sck_w[0] or negedge cs_w[0]) begin
    if (sck_w[0]) idx_a = pw(0) - 1;
    else if (!cs_w[0]) begin
      if (idx_a >= 0) sdout_a = pat_v[0][idx_a];
      idx_a--;
    end
  end
  always @(negedge sck_w[1] or negedge cs_w[1]) begin
    if (sck_w[1]) idx_b = pw(1) - 1;
    else if (!cs_w[1]) begin
      if (idx_b >= 0) sdout_b = pat_v[1][idx_b];
      idx_b--;
    end
  end

  // DAC side: record SDIN at every SCK rise while selected.
  logic [31:0] cap_a = '0;
  logic [31:0] cap_b = '0;
  always @(posedge sck_w[0]) if (!cs_w[0]) cap_a <= {cap_a[30:0], sdin_w[0]};
  always @(posedge sck_w[1]) if (!cs_w[1]) cap_b <= {cap_b[30:0], sdin_w[1]};

  int n_done_a = 0;
  always @(negedge clk) if (done_w[0]) n_done_a++;

  // ---------------- Frame model: accept time, word and expected sample ----
  bit          m_active [2];
  int          m_t      [2];
  logic [31:0] m_word   [2];
  logic [31:0] m_pat    [2];
  logic [31:0] m_adc    [2];

  always @(posedge clk or negedge rst_n) begin : p_model
    bit          idle_prev;
    logic [31:0] d, ch;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] <= 1'b0;
        m_adc[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        idle_prev = !m_active[i] || (cyc - m_t[i] > fend(i) + pd(i));
        if (idle_prev) begin
          m_active[i] <= start_v[i];
          if (start_v[i]) begin
            d  = loop_v[i] ? m_adc[i] : ((i == 0) ? {20'b0, data_a} : {16'b0, data_b});
            ch = (i == 0) ? {30'b0, ch_a} : {28'b0, ch_b};
            m_t[i]    <= cyc;
            m_word[i] <= (ch << (pw(i) - pcw(i))) | d;
            m_pat[i]  <= pat_v[i];
          end
        end else if (cyc + 1 - m_t[i] == fend(i)) begin
          m_adc[i] <= m_pat[i] & ((32'd1 << pdw(i)) - 32'd1);
        end
      end
    end
  end

  // ---------------- Per-cycle comparison against the model ----------------
  always @(negedge clk) begin : p_compare
    int    k, tt, dd, ww, b;
    bit    inf;
    logic  e_cs, e_sck;
    string p;
    logic [31:0] act_adc;
    for (int i = 0; i < 2; i++) begin
      p       = (i == 0) ? "A" : "B";
      act_adc = (i == 0) ? {20'b0, adc_a} : {16'b0, adc_b};
      if (!rst_n) begin
        check({p, " reset SCK"}, 32'(sck_w[i]), 32'd1);
        check({p, " reset CS_ADC"}, 32'(cs_w[i]), 32'd1);
        check({p, " reset LD_DAC"}, 32'(ld_w[i]), 32'd1);
        check({p, " reset SDIN"}, 32'(sdin_w[i]), 32'd0);
        check({p, " reset BUSY"}, 32'(busy_w[i]), 32'd0);
        check({p, " reset DONE"}, 32'(done_w[i]), 32'd0);
        check({p, " reset ADC_DATA"}, act_adc, 32'd0);
      end else begin
        tt  = fend(i);
        dd  = pd(i);
        ww  = pw(i);
        k   = cyc - m_t[i];
        inf = m_active[i] && (k >= 1) && (k <= tt + dd);
        e_cs  = !(inf && (k < tt));
        e_sck = 1'b1;
        if (inf && (k >= 1 + dd) && (k < 1 + dd + 2 * ww * dd))
          e_sck = ((k - 1 - dd) % (2 * dd)) >= dd;
        check({p, " BUSY"}, 32'(busy_w[i]), 32'(inf));
        check({p, " DONE"}, 32'(done_w[i]), 32'(inf && (k == tt)));
        check({p, " CS_ADC"}, 32'(cs_w[i]), 32'(e_cs));
        check({p, " LD_DAC"}, 32'(ld_w[i]), 32'(e_cs));
        check({p, " SCK"}, 32'(sck_w[i]), 32'(e_sck));
        check({p, " ADC_DATA"}, act_adc, m_adc[i]);
        if (!e_cs) begin
          b = (k < 1 + dd) ? 0 : (k - 1 - dd) / (2 * dd);
          if (b > ww - 1) b = ww - 1;
          check({p, " SDIN"}, 32'(sdin_w[i]), 32'(m_word[i][ww-1-b]));
        end
      end
    end
  end

  // ---------------- Directed frames with literal expectations -------------
  task automatic set_inputs(input int i, input logic [31:0] ch, input logic [31:0] data,
                            input bit lb, input logic [31:0] pat);
    pat_v[i]  = pat;
    loop_v[i] = lb;
    if (i == 0) begin ch_a = ch[1:0]; data_a = data[11:0]; end
    else        begin ch_b = ch[3:0]; data_b = data[15:0]; end
  endtask

  task automatic wait_idle(input int i, input int budget, input int t, input int exp_off);
    bit got;
    got = 1'b0;
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge clk);
      if (!busy_w[i]) got = 1'b1;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL busy-release timeout: BUSY still 1, required 0");
    end else if (exp_off >= 0) begin
      check("BUSY release offset", 32'(cyc - t), 32'(exp_off));
    end
  endtask

  task automatic run_frame(input int i, input logic [31:0] ch, input logic [31:0] data,
                           input bit lb, input logic [31:0] pat, input logic [31:0] exp_word,
                           input logic [31:0] exp_adc, input int exp_done, input int exp_idle);
    int t, d;
    bit got;
    logic [31:0] cap;
    set_inputs(i, ch, data, lb, pat);
    @(negedge clk);
    start_v[i] = 1'b1;
    t = cyc;
    @(negedge clk);
    start_v[i] = 1'b0;
    loop_v[i]  = ~lb;           // must not disturb the frame in flight
    got = 1'b0;
    d   = 0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (done_w[i]) begin got = 1'b1; d = cyc; end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL DONE timeout: no DONE pulse, required one at offset %0d", exp_done);
    end else begin
      check("DONE offset", 32'(d - t), 32'(exp_done));
      @(negedge clk);
      check("ADC_DATA after frame", (i == 0) ? {20'b0, adc_a} : {16'b0, adc_b}, exp_adc);
      cap = (i == 0) ? {16'b0, cap_a[15:0]} : {8'b0, cap_b[23:0]};
      check("SDIN word at SCK rises", cap, exp_word);
      wait_idle(i, 20, t, exp_idle);
    end
  endtask

  initial begin
    int nd, t;
    int dq[$];
    pat_v[0] = '0;
    pat_v[1] = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    nd = n_done_a;
    repeat (50) @(negedge clk);
    check("idle DONE count", 32'(n_done_a - nd), 32'd0);
    check("idle SCK", 32'(sck_w[0]), 32'd1);
    check("idle CS_ADC", 32'(cs_w[0]), 32'd1);
    check("idle BUSY", 32'(busy_w[0]), 32'd0);
    check("idle ADC_DATA", {20'b0, adc_a}, 32'd0);

    // Basic frame, then loopback frame using the captured 0x123.
    run_frame(0, 32'd2, 32'hA5C, 1'b0, 32'h0123, 32'h8A5C, 32'h123, 137, 142);
    run_frame(0, 32'd1, 32'hFFF, 1'b1, 32'h0FED, 32'h4123, 32'hFED, 137, 142);

    // START held high: accepts only at t, t+142, t+284.
    set_inputs(0, 32'd3, 32'h0F0, 1'b0, 32'hABCD);
    @(negedge clk);
    start_v[0] = 1'b1;
    t = cyc;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done_w[0]) dq.push_back(cyc - t);
    end
    start_v[0] = 1'b0;
    check("storm DONE count", 32'(dq.size()), 32'd2);
    if (dq.size() >= 2) begin
      check("storm first DONE", 32'(dq[0]), 32'd137);
      check("storm second DONE", 32'(dq[1]), 32'd279);
    end
    wait_idle(0, 300, t, -1);
    check("storm ADC_DATA", {20'b0, adc_a}, 32'hBCD);

    // Reset in the middle of SHIFT bit 7 (SCK low at this point).
    set_inputs(0, 32'd0, 32'h555, 1'b0, 32'h0777);
    @(negedge clk);
    start_v[0] = 1'b1;
    t = cyc;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (61) @(negedge clk);
    check("pre-reset SCK low", 32'(sck_w[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async reset SCK", 32'(sck_w[0]), 32'd1);
    check("async reset CS_ADC", 32'(cs_w[0]), 32'd1);
    check("async reset LD_DAC", 32'(ld_w[0]), 32'd1);
    check("async reset BUSY", 32'(busy_w[0]), 32'd0);
    check("async reset ADC_DATA", {20'b0, adc_a}, 32'd0);
    nd = n_done_a;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    check("aborted frame DONE count", 32'(n_done_a - nd), 32'd0);
    run_frame(0, 32'd2, 32'h321, 1'b0, 32'h0456, 32'h8321, 32'h456, 137, 142);

    // Wide, fast instance.
    run_frame(1, 32'hB, 32'h3C5A, 1'b0, 32'h12F00D, 32'hB03C5A, 32'hF00D, 51, 53);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
